// File: rtl/syncer_pkg.sv
// syncer_pkg: shared state encoding and width helper for the pulse syncer family
package syncer_pkg;
    typedef enum logic {IDLE, WAIT_ACK} pulse_tx_state_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/syncer_pulse_tx_chan.sv
// syncer_pulse_tx_chan: one req/ack toggle channel with event queueing and sticky status
// Optional ack timeout flag is built when SYNC_PULSE_TIMEOUT_EN is defined.
module syncer_pulse_tx_chan
    import syncer_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int EDGE_MODE   = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    input  logic ack_toggle_in,
    input  logic clr_status,
    output logic req_toggle,
    output logic busy,
    output logic overflow,
    output logic timeout_err
);
    localparam logic [CNT_W-1:0] FULL = '1;
    logic pulse_d1, ev, issue, match;
    logic [CNT_W-1:0] pending, pending_nx;
    pulse_tx_state_e state, state_nx;
    always_comb begin
        ev = (EDGE_MODE != 0) ? (pulse_in & ~pulse_d1) : pulse_in;
        issue = (state == IDLE) && (pending != '0);
        match = (state == WAIT_ACK) && (ack_toggle_in == req_toggle);
        // an issue frees a slot, so a coincident event never overflows
        pending_nx = issue ? (ev ? pending : pending - 1'b1)
                   : (ev && pending != FULL) ? pending + 1'b1 : pending;
        state_nx = issue ? WAIT_ACK : match ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_d1   <= 1'b0;
            pending    <= '0;
            state      <= IDLE;
            req_toggle <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pulse_d1   <= pulse_in;
            pending    <= pending_nx;
            state      <= state_nx;
            req_toggle <= req_toggle ^ issue;
            busy       <= (state_nx == WAIT_ACK) || (pending_nx != '0);
            overflow   <= (ev && pending == FULL && !issue) | (overflow & ~clr_status);
        end
    end
`ifdef SYNC_PULSE_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
    logic [TW-1:0] tcnt, tcnt_nx;
    always_comb tcnt_nx = (state == WAIT_ACK && !match) ? ((tcnt == TMAX) ? tcnt : tcnt + 1'b1) : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= tcnt_nx;
            timeout_err <= (tcnt != TMAX && tcnt_nx == TMAX) | (timeout_err & ~clr_status);
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: rtl/syncer_pulse_tx_multi.sv
// syncer_pulse_tx_multi: NUM_CH independent req/ack toggle pulse transmitters
// Ack timeout flags are built only when SYNC_PULSE_TIMEOUT_EN is defined.
module syncer_pulse_tx_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 4,
    parameter int EDGE_MODE   = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pulse_in,
    input  logic [NUM_CH-1:0] ack_toggle_in,
    input  logic              clr_status,
    output logic [NUM_CH-1:0] req_toggle,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] overflow,
    output logic [NUM_CH-1:0] timeout_err
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        syncer_pulse_tx_chan #(
            .CNT_W      (CNT_W),
            .EDGE_MODE  (EDGE_MODE),
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .pulse_in     (pulse_in[g]),
            .ack_toggle_in(ack_toggle_in[g]),
            .clr_status   (clr_status),
            .req_toggle   (req_toggle[g]),
            .busy         (busy[g]),
            .overflow     (overflow[g]),
            .timeout_err  (timeout_err[g])
        );
    end
endmodule

// File: tb/tb_syncer_pulse_tx_multi.sv
// tb_syncer_pulse_tx_multi: scoreboard bench for the multi-channel pulse transmitter
module tb_syncer_pulse_tx_multi;
    localparam int NUM_CH = 4;
    localparam int TC = 8;

    logic clk = 1'b0, reset = 1'b1, clr_status = 1'b0;
    logic [NUM_CH-1:0] pulse_in = '0, ack_toggle_in = '0;
    logic [NUM_CH-1:0] req_toggle, busy, overflow, timeout_err;
    logic pulse_m = 1'b0, ack_m = 1'b0, req_m, busy_m, ovf_m, to_m;

    int n_chk = 0, n_fail = 0;
    logic q [NUM_CH][$];
    logic exp_lvl [NUM_CH];
    int dly [NUM_CH], acnt [NUM_CH], tog_cnt [NUM_CH];
    bit hold [NUM_CH], match_now [NUM_CH];
    logic [NUM_CH-1:0] req_prev = '0;
    logic req_m_prev = 1'b0;
    int m_toggles = 0;

    always #5 clk = ~clk;

    syncer_pulse_tx_multi #(.NUM_CH(NUM_CH), .CNT_W(4), .EDGE_MODE(1), .TIMEOUT_CYC(TC)) dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .ack_toggle_in(ack_toggle_in),
        .clr_status(clr_status), .req_toggle(req_toggle), .busy(busy),
        .overflow(overflow), .timeout_err(timeout_err));

    syncer_pulse_tx_multi #(.NUM_CH(1), .CNT_W(4), .EDGE_MODE(0), .TIMEOUT_CYC(TC)) dut_lvl (
        .clk(clk), .reset(reset), .pulse_in(pulse_m), .ack_toggle_in(ack_m),
        .clr_status(clr_status), .req_toggle(req_m), .busy(busy_m),
        .overflow(ovf_m), .timeout_err(to_m));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_toggle(input int c);
        exp_lvl[c] = ~exp_lvl[c];
        q[c].push_back(exp_lvl[c]);
    endtask

    task automatic pulse(input int c);
        pulse_in[c] = 1'b1;
        tick();
        pulse_in[c] = 1'b0;
        tick();
    endtask

    task automatic drain(input int c, input string tag);
        int t;
        t = 0;
        while ((q[c].size() != 0 || busy[c]) && t < 500) begin
            tick();
            t++;
        end
        check(tag, (q[c].size() == 0 && !busy[c]), 1);
    endtask

    // far-domain model: echoes req back dly cycles after it changes
    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                acnt[c] = 0;
                ack_toggle_in[c] = 1'b0;
            end else if (match_now[c]) begin
                ack_toggle_in[c] = req_toggle[c];
                match_now[c] = 1'b0;
            end else if (!hold[c] && req_toggle[c] !== ack_toggle_in[c]) begin
                acnt[c]++;
                if (acnt[c] > dly[c]) begin
                    ack_toggle_in[c] = req_toggle[c];
                    acnt[c] = 0;
                end
            end else acnt[c] = 0;
        end
        ack_m = reset ? 1'b0 : req_m;
    end

    // scoreboard: every observed req toggle must match the next queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (req_toggle[c] !== req_prev[c]) begin
                    tog_cnt[c]++;
                    if (q[c].size() == 0) check($sformatf("unexpected_toggle_ch%0d", c), req_toggle[c], req_prev[c]);
                    else check($sformatf("toggle_level_ch%0d", c), req_toggle[c], q[c].pop_front());
                end
            end
            if (req_m !== req_m_prev) m_toggles++;
        end
        req_prev = req_toggle;
        req_m_prev = req_m;
    end

    initial begin
        int t, base;
        for (int c = 0; c < NUM_CH; c++) begin
            dly[c] = 3;
            hold[c] = 1'b0;
            match_now[c] = 1'b0;
            exp_lvl[c] = 1'b0;
            tog_cnt[c] = 0;
            acnt[c] = 0;
        end
        tick(3);
        check("rst_req", req_toggle, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_to", timeout_err, 0);
        check("rst_req_lvl", req_m, 0);
        reset = 1'b0;
        tick(2);

        // single pulse on ch0 with a 3-cycle ack loop
        pulse_in[0] = 1'b1;
        expect_toggle(0);
        for (int k = 0; k < 8; k++) begin
            if (k == 1) pulse_in[0] = 1'b0;
            check($sformatf("t1_busy_k%0d", k), busy[0], (k >= 1 && k <= 5));
            check($sformatf("t1_req_k%0d", k), req_toggle[0], (k >= 2));
            tick();
        end
        check("t1_queue_empty", q[0].size(), 0);

        // burst of 6 edges on ch1 during a slow handshake
        dly[1] = 20;
        base = tog_cnt[1];
        for (int i = 0; i < 6; i++) begin
            expect_toggle(1);
            pulse(1);
        end
        drain(1, "t2_drain");
        check("t2_toggles", tog_cnt[1] - base, 6);
        check("t2_ovf", overflow[1], 0);

        // overflow on ch2: ack held, 1 issued + 15 queued + 1 dropped
        hold[2] = 1'b1;
        expect_toggle(2);
        pulse(2);
        tick(2);
        check("t3_first_issue", req_toggle[2], 1);
        for (int i = 0; i < 15; i++) begin
            expect_toggle(2);
            pulse(2);
        end
        check("t3_ovf_at_15", overflow[2], 0);
        pulse(2);
        check("t3_ovf_at_16", overflow[2], 1);
        check("t3_ovf_other", overflow[1:0], 0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("t3_ovf_clr", overflow[2], 0);

        // event coincident with an issue at pending=15
        @(posedge clk);
        match_now[2] = 1'b1;
        tick();
        tick();
        pulse_in[2] = 1'b1;
        expect_toggle(2);
        tick();
        pulse_in[2] = 1'b0;
        check("t4_coinc_ovf", overflow[2], 0);
        tick();
        pulse_in[2] = 1'b1;
        tick();
        pulse_in[2] = 1'b0;
        check("t4_still_full", overflow[2], 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        dly[2] = 1;
        hold[2] = 1'b0;
        drain(2, "t4_drain");
        check("t4_ovf_after", overflow[2], 0);

        // level mode: 3 high cycles make 3 toggles
        pulse_m = 1'b1;
        tick(3);
        pulse_m = 1'b0;
        t = 0;
        while ((m_toggles < 3 || busy_m) && t < 60) begin
            tick();
            t++;
        end
        tick(3);
        check("t5_lvl_toggles", m_toggles, 3);
        check("t5_lvl_busy", busy_m, 0);

        // reset in the middle of a handshake on ch3
        hold[3] = 1'b1;
        expect_toggle(3);
        pulse(3);
        tick(2);
        check("t5_pre_rst_busy", busy[3], 1);
        check("t5_pre_rst_req", req_toggle[3], 1);
        reset = 1'b1;
        tick();
        check("t5_rst_req", req_toggle, 0);
        check("t5_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            exp_lvl[c] = 1'b0;
        end
        tick(2);

        // ack never returns on ch3
        pulse_in[3] = 1'b1;
        expect_toggle(3);
        t = 0;
        while (req_toggle[3] !== 1'b1 && t < 10) begin
            tick();
            pulse_in[3] = 1'b0;
            t++;
        end
        check("t6_entered_wait", req_toggle[3], 1);
`ifdef SYNC_PULSE_TIMEOUT_EN
        tick(7);
        check("t6_to_before", timeout_err[3], 0);
        tick();
        check("t6_to_set", timeout_err[3], 1);
        check("t6_busy_waiting", busy[3], 1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("t6_to_clr", timeout_err[3], 0);
        tick(10);
        check("t6_no_retoggle", req_toggle[3], 1);
`else
        tick(20);
        check("t6_to_off", timeout_err, 0);
        check("t6_no_retoggle", req_toggle[3], 1);
`endif
        for (int c = 0; c < 3; c++) check($sformatf("final_queue_ch%0d", c), q[c].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
